// File: rtl/dsp_sys_pkg.sv
// Shared types and constants for the DSP system memory path.
package dsp_sys_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int MEM_ADDR_W             = 32;
  localparam int MEM_DATA_W             = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Counter that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first active requester after last_grant wins.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last_grant,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [2:0]         grant_idx,
  output logic               any_req
);

  logic found;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    any_req   = |req;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && ((int'(last_grant) + k) % NUM_REQ) == i) begin
          found     = 1'b1;
          grant_idx = 3'(i);
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign grant_onehot[gi] = any_req && (grant_idx == 3'(gi));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises NUM_REQ requesters onto the single memory request port,
// with a response timeout so a stalled controller cannot hang a requester.
module mem_arbiter
  import dsp_sys_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       req_err,
  output logic [DATA_W-1:0]          req_rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy,
  output logic [2:0]                 grant_id,
  output logic [7:0]                 timeout_count
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  arb_state_t           state_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [2:0]           last_grant_reg;
  logic [NUM_REQ-1:0]   grant_oh_reg;
  logic [NUM_REQ-1:0]   req_ack_reg;
  logic                 req_err_reg;
  logic [DATA_W-1:0]    req_rdata_reg;
  logic                 mem_req_reg;
  logic                 mem_we_reg;
  logic [ADDR_W-1:0]    mem_addr_reg;
  logic [DATA_W-1:0]    mem_wdata_reg;
  logic                 busy_reg;
  logic [2:0]           grant_id_reg;
  logic [7:0]           timeout_count_reg;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [2:0]           pick_idx;
  logic                 any_req;

  logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]    wdata_arr [NUM_REQ];
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req          (req_valid),
    .last_grant   (last_grant_reg),
    .grant_onehot (pick_oh),
    .grant_idx    (pick_idx),
    .any_req      (any_req)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == 3'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = addr_arr[i];
        sel_wdata = wdata_arr[i];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg         <= IDLE;
      timer_reg         <= '0;
      last_grant_reg    <= 3'(NUM_REQ - 1);
      grant_oh_reg      <= '0;
      req_ack_reg       <= '0;
      req_err_reg       <= 1'b0;
      req_rdata_reg     <= '0;
      mem_req_reg       <= 1'b0;
      mem_we_reg        <= 1'b0;
      mem_addr_reg      <= '0;
      mem_wdata_reg     <= '0;
      busy_reg          <= 1'b0;
      grant_id_reg      <= '0;
      timeout_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            mem_req_reg    <= 1'b1;
            mem_we_reg     <= sel_we;
            mem_addr_reg   <= sel_addr;
            mem_wdata_reg  <= sel_wdata;
            grant_id_reg   <= pick_idx;
            last_grant_reg <= pick_idx;
            grant_oh_reg   <= pick_oh;
            timer_reg      <= '0;
            busy_reg       <= 1'b1;
            state_reg      <= WAIT;
          end
        end
        WAIT: begin
          timer_reg <= timer_reg + TIMER_W'(1);
          // A late ack on the final timer cycle still counts as success.
          if (mem_ack) begin
            mem_req_reg   <= 1'b0;
            req_ack_reg   <= grant_oh_reg;
            req_rdata_reg <= mem_rdata;
            req_err_reg   <= 1'b0;
            state_reg     <= DONE;
          end else if (timer_reg == TIMER_LAST) begin
            mem_req_reg       <= 1'b0;
            req_ack_reg       <= grant_oh_reg;
            req_rdata_reg     <= '0;
            req_err_reg       <= 1'b1;
            timeout_count_reg <= sat_inc8(timeout_count_reg);
            state_reg         <= DONE;
          end
        end
        DONE: begin
          req_ack_reg <= '0;
          req_err_reg <= 1'b0;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ack       = req_ack_reg;
  assign req_err       = req_err_reg;
  assign req_rdata     = req_rdata_reg;
  assign mem_req       = mem_req_reg;
  assign mem_we        = mem_we_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign busy          = busy_reg;
  assign grant_id      = grant_id_reg;
  assign timeout_count = timeout_count_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference plus directed scenarios.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 16;

  logic            clk_sys = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ack;
  logic            req_err;
  logic [DW-1:0]   req_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic            busy;
  logic [2:0]      grant_id;
  logic [7:0]      timeout_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic checking = 1'b0;

  always #5 clk_sys = ~clk_sys;

  mem_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id), .timeout_count(timeout_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory controller stand-in: acks once mem_req has been seen high ack_lat cycles
  int          ack_lat = 0;
  logic [31:0] rd_val = '0;
  logic        stray = 1'b0;
  int          hi_cnt = 0;
  always begin
    @(posedge clk_sys);
    #1;
    mem_ack = 1'b0;
    if (mem_req) begin
      hi_cnt++;
      if (ack_lat > 0 && hi_cnt == ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_val;
      end
    end else begin
      hi_cnt = 0;
      if (stray) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Reference: one transaction at a time, rotating search, fixed-length timeout
  int          m_phase, m_last, m_age, m_win;
  logic [N-1:0] e_ack;
  logic        e_err, e_req, e_we, e_busy;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [2:0]  e_gid;
  int          e_tc;

  always @(posedge clk_sys) begin
    if (reset) begin
      m_phase = 0; m_last = N - 1; m_age = 0;
      e_ack = '0; e_err = 0; e_req = 0; e_we = 0; e_busy = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0; e_gid = '0; e_tc = 0;
    end else if (m_phase == 0) begin
      m_win = -1;
      for (int k = 1; k <= N && m_win < 0; k++)
        if (req_valid[(m_last + k) % N]) m_win = (m_last + k) % N;
      if (m_win >= 0) begin
        e_req   = 1'b1;
        e_we    = req_we[m_win];
        e_addr  = req_addr[m_win*AW +: AW];
        e_wdata = req_wdata[m_win*DW +: DW];
        e_gid   = 3'(m_win);
        e_busy  = 1'b1;
        m_last  = m_win;
        m_age   = 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_ack || m_age == T) begin
        e_req = 1'b0;
        e_ack = '0;
        e_ack[m_last] = 1'b1;
        e_err   = !mem_ack;
        e_rdata = mem_ack ? mem_rdata : 32'h0;
        if (!mem_ack && e_tc < 255) e_tc++;
        m_phase = 2;
      end else begin
        m_age++;
      end
    end else begin
      e_ack = '0; e_err = 1'b0; e_busy = 1'b0;
      m_phase = 0;
    end
  end

  always @(negedge clk_sys) begin
    if (checking) begin
      chk("req_ack", req_ack, e_ack);
      chk("req_err", req_err, e_err);
      chk("req_rdata", req_rdata, e_rdata);
      chk("mem_req", mem_req, e_req);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("busy", busy, e_busy);
      chk("grant_id", grant_id, e_gid);
      chk("timeout_count", timeout_count, 64'(e_tc));
    end
  end

  // Observation for the directed literal checks
  int          run = 0, last_run = 0, ack_cnt = 0;
  logic        prev_req = 1'b0;
  logic [N-1:0] last_ack = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          grants[$];

  always @(negedge clk_sys) begin
    if (mem_req) run++;
    else if (run > 0) begin last_run = run; run = 0; end
    if (mem_req && !prev_req) grants.push_back(int'(grant_id));
    prev_req = mem_req;
    if (req_ack != '0) begin
      ack_cnt++;
      last_ack = req_ack; last_rdata = req_rdata; last_err = req_err;
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic wait_ack(input string name, input int max);
    int start;
    int got;
    start = ack_cnt;
    got = 0;
    for (int i = 0; i < max && got == 0; i++) begin
      tick();
      if (ack_cnt != start) got = 1;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  task automatic wait_req(input string name, input int max);
    int got;
    got = 0;
    for (int i = 0; i < max && got == 0; i++) begin
      tick();
      if (mem_req) got = 1;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  initial begin
    int saved;
    reset = 1'b1;
    repeat (2) tick();
    checking = 1'b1;
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_timeout_count", timeout_count, 0);
    reset = 1'b0;
    tick();

    // Single read from requester 0
    ack_lat = 5; rd_val = 32'hCAFE_F00D;
    req_addr[0 +: AW] = 32'h0000_1000;
    req_valid[0] = 1'b1;
    saved = ack_cnt;
    wait_ack("rd_wait", 40);
    req_valid[0] = 1'b0;
    repeat (3) tick();
    chk("rd_ack_vec", last_ack, 3'b001);
    chk("rd_rdata", last_rdata, 32'hCAFE_F00D);
    chk("rd_err", last_err, 0);
    chk("rd_req_len", 64'(last_run), 5);
    chk("rd_ack_pulses", 64'(ack_cnt - saved), 1);

    // Address latched at grant
    ack_lat = 8;
    req_addr[1*AW +: AW]  = 32'h10;
    req_wdata[1*DW +: DW] = 32'h55;
    req_we[1] = 1'b1;
    req_valid[1] = 1'b1;
    wait_req("latch_req", 10);
    req_addr[1*AW +: AW] = 32'h20;
    repeat (3) tick();
    chk("latch_addr_mid", mem_addr, 32'h10);
    wait_ack("latch_wait", 20);
    req_valid[1] = 1'b0;
    chk("latch_ack_vec", last_ack, 3'b010);
    chk("latch_addr_end", mem_addr, 32'h10);
    req_we[1] = 1'b0;

    // Fairness with all requesters held, plus acks arriving outside WAIT
    reset = 1'b1; tick(); reset = 1'b0; tick();
    grants.delete();
    ack_lat = 1; rd_val = 32'h0000_00A5; stray = 1'b1;
    req_addr[0 +: AW] = 32'hA0; req_addr[1*AW +: AW] = 32'hA1; req_addr[2*AW +: AW] = 32'hA2;
    req_we[1] = 1'b1;
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) wait_ack("fair_wait", 20);
    req_valid = '0; stray = 1'b0; req_we = '0;
    repeat (3) tick();
    chk("fair_count", 64'(grants.size()), 6);
    if (grants.size() >= 6) begin
      chk("fair_g0", 64'(grants[0]), 0);
      chk("fair_g1", 64'(grants[1]), 1);
      chk("fair_g2", 64'(grants[2]), 2);
      chk("fair_g3", 64'(grants[3]), 0);
      chk("fair_g4", 64'(grants[4]), 1);
      chk("fair_g5", 64'(grants[5]), 2);
    end

    // Timeout
    ack_lat = 0;
    req_valid[2] = 1'b1;
    wait_ack("to_wait", 40);
    req_valid[2] = 1'b0;
    tick();
    chk("to_ack_vec", last_ack, 3'b100);
    chk("to_err", last_err, 1);
    chk("to_rdata", last_rdata, 0);
    chk("to_req_len", 64'(last_run), 16);
    chk("to_count", timeout_count, 1);

    // Ack on the last timer cycle wins
    ack_lat = T; rd_val = 32'h1234_5678;
    req_valid[0] = 1'b1;
    wait_ack("col_wait", 40);
    req_valid[0] = 1'b0;
    tick();
    chk("col_err", last_err, 0);
    chk("col_rdata", last_rdata, 32'h1234_5678);
    chk("col_req_len", 64'(last_run), 16);
    chk("col_count", timeout_count, 1);

    // Saturation
    ack_lat = 0;
    for (int i = 0; i < 300; i++) begin
      req_valid[2] = 1'b1;
      wait_ack("sat_wait", 40);
      req_valid[2] = 1'b0;
      tick();
    end
    chk("sat_count", timeout_count, 255);

    // Reset in the middle of a transaction
    req_valid = 3'b010;
    wait_req("mid_req", 10);
    repeat (3) tick();
    chk("mid_grant", grant_id, 1);
    saved = ack_cnt;
    req_valid = 3'b111;
    reset = 1'b1;
    tick();
    chk("mid_mem_req", mem_req, 0);
    chk("mid_busy", busy, 0);
    reset = 1'b0;
    chk("mid_no_ack", 64'(ack_cnt), 64'(saved));
    grants.delete();
    ack_lat = 2;
    wait_ack("mid_after_wait", 20);
    req_valid = '0;
    chk("mid_after_ack", last_ack, 3'b001);
    if (grants.size() > 0) chk("mid_first_grant", 64'(grants[0]), 0);
    else chk("mid_first_grant_seen", 64'(grants.size()), 1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
